// File: rtl/am_query_sequencer.sv
// Serializes a full query hypervector into SEQ_CYCLE_COUNT segments for the AM AND array.
// Optional AM_QUERY_DENSITY_EN adds a per-query popcount output (query_density).
module am_query_sequencer #(
  parameter int DIMS_PER_CC     = 64,
  parameter int SEQ_CYCLE_COUNT = 10
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   q_valid,
  output logic                                   q_ready,
  input  logic [SEQ_CYCLE_COUNT*DIMS_PER_CC-1:0] q_hv,
  output logic                                   seg_valid,
  input  logic                                   seg_ready,
  output logic [3:0]                             query_ctr,
  output logic [DIMS_PER_CC-1:0]                 query_hv_segment,
  output logic                                   seg_first,
  output logic                                   seg_last,
`ifdef AM_QUERY_DENSITY_EN
  output logic                                   busy,
  output logic [$clog2(SEQ_CYCLE_COUNT*DIMS_PER_CC+1)-1:0] query_density
`else
  output logic                                   busy
`endif
);

  localparam int QW = SEQ_CYCLE_COUNT * DIMS_PER_CC;
  localparam int IW = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1;
  localparam logic [3:0] LAST_CTR = 4'(SEQ_CYCLE_COUNT - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state_reg, state_next;
  logic [QW-1:0]        active_hv_reg, active_hv_next;
  logic [QW-1:0]        pending_hv_reg, pending_hv_next;
  logic                 pending_full_reg, pending_full_next;
  logic                 seg_valid_reg, seg_valid_next;
  logic [3:0]           ctr_reg, ctr_next;
  logic [DIMS_PER_CC-1:0] seg_reg, seg_next;
  logic                 first_reg, first_next;
  logic                 last_reg, last_next;
  logic                 ready_en_reg;

  logic q_xfer, s_xfer;
  logic [DIMS_PER_CC-1:0] next_segs [SEQ_CYCLE_COUNT];

  // Slices of the query that will be active next cycle, so the segment output is registered.
  genvar gi;
  generate
    for (gi = 0; gi < SEQ_CYCLE_COUNT; gi++) begin : g_seg
      assign next_segs[gi] = active_hv_next[gi*DIMS_PER_CC +: DIMS_PER_CC];
    end
  endgenerate

  assign q_ready = ready_en_reg && !pending_full_reg;
  assign q_xfer  = q_valid && q_ready;
  assign s_xfer  = seg_valid_reg && seg_ready;

`ifdef AM_QUERY_DENSITY_EN
  localparam int DW = $clog2(QW + 1);
  logic [DW-1:0] in_density;
  logic [DW-1:0] active_dens_reg, active_dens_next;
  logic [DW-1:0] pending_dens_reg, pending_dens_next;

  always_comb begin
    in_density = '0;
    for (int i = 0; i < QW; i++) begin
      in_density = in_density + DW'(q_hv[i]);
    end
  end
`endif

  always_comb begin
    state_next        = state_reg;
    active_hv_next    = active_hv_reg;
    pending_hv_next   = pending_hv_reg;
    pending_full_next = pending_full_reg;
    seg_valid_next    = seg_valid_reg;
    ctr_next          = ctr_reg;
`ifdef AM_QUERY_DENSITY_EN
    active_dens_next  = active_dens_reg;
    pending_dens_next = pending_dens_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (q_xfer) begin
          active_hv_next = q_hv;
`ifdef AM_QUERY_DENSITY_EN
          active_dens_next = in_density;
`endif
          ctr_next       = 4'd0;
          seg_valid_next = 1'b1;
          state_next     = STREAM;
        end
      end
      STREAM: begin
        if (s_xfer && ctr_reg != LAST_CTR) begin
          ctr_next = ctr_reg + 4'd1;
          if (q_xfer) begin
            pending_hv_next   = q_hv;
            pending_full_next = 1'b1;
`ifdef AM_QUERY_DENSITY_EN
            pending_dens_next = in_density;
`endif
          end
        end else if (s_xfer) begin
          ctr_next = 4'd0;
          if (pending_full_reg) begin
            active_hv_next    = pending_hv_reg;
            pending_full_next = 1'b0;
`ifdef AM_QUERY_DENSITY_EN
            active_dens_next  = pending_dens_reg;
`endif
          end else if (q_xfer) begin
            active_hv_next = q_hv;
`ifdef AM_QUERY_DENSITY_EN
            active_dens_next = in_density;
`endif
          end else begin
            seg_valid_next = 1'b0;
            state_next     = IDLE;
          end
        end else if (q_xfer) begin
          pending_hv_next   = q_hv;
          pending_full_next = 1'b1;
`ifdef AM_QUERY_DENSITY_EN
          pending_dens_next = in_density;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
    seg_next   = seg_valid_next ? next_segs[ctr_next[IW-1:0]] : '0;
    first_next = seg_valid_next && (ctr_next == 4'd0);
    last_next  = seg_valid_next && (ctr_next == LAST_CTR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      active_hv_reg    <= '0;
      pending_hv_reg   <= '0;
      pending_full_reg <= 1'b0;
      seg_valid_reg    <= 1'b0;
      ctr_reg          <= 4'd0;
      seg_reg          <= '0;
      first_reg        <= 1'b0;
      last_reg         <= 1'b0;
      ready_en_reg     <= 1'b0;
`ifdef AM_QUERY_DENSITY_EN
      active_dens_reg  <= '0;
      pending_dens_reg <= '0;
`endif
    end else begin
      state_reg        <= state_next;
      active_hv_reg    <= active_hv_next;
      pending_hv_reg   <= pending_hv_next;
      pending_full_reg <= pending_full_next;
      seg_valid_reg    <= seg_valid_next;
      ctr_reg          <= ctr_next;
      seg_reg          <= seg_next;
      first_reg        <= first_next;
      last_reg         <= last_next;
      ready_en_reg     <= 1'b1;
`ifdef AM_QUERY_DENSITY_EN
      active_dens_reg  <= active_dens_next;
      pending_dens_reg <= pending_dens_next;
`endif
    end
  end

  assign seg_valid        = seg_valid_reg;
  assign query_ctr        = ctr_reg;
  assign query_hv_segment = seg_reg;
  assign seg_first        = first_reg;
  assign seg_last         = last_reg;
  assign busy             = (state_reg == STREAM) || pending_full_reg;
`ifdef AM_QUERY_DENSITY_EN
  assign query_density    = seg_valid_reg ? active_dens_reg : '0;
`endif

endmodule

// File: doc/am_query_sequencer.md
Name: am_query_sequencer

Overview:
- Source side of the associative-memory AND array.
- Accepts a full sparse query hypervector over a valid/ready handshake and serializes it into SEQ_CYCLE_COUNT segments of DIMS_PER_CC bits.
- Each segment is driven with the matching query_ctr index, so the AND array and downstream popcount logic see segment k paired with class-HV slice k.
- A two-deep query buffer lets the next query be accepted while the current one streams, giving zero bubble between back-to-back queries.

Parameters:
- DIMS_PER_CC, 64, bits per segment (width of query_hv_segment).
- SEQ_CYCLE_COUNT, 10, segments per query; legal range 1..16 because query_ctr is 4 bits.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- q_valid  input  1  upstream query available.
- q_ready  output  1  block can accept a query this cycle.
- q_hv  input  SEQ_CYCLE_COUNT*DIMS_PER_CC  full query HV; segment k = q_hv[k*DIMS_PER_CC +: DIMS_PER_CC].
- seg_valid  output  1  segment outputs valid.
- seg_ready  input  1  downstream accepts the segment.
- query_ctr  output  4  index of the current segment, 0..SEQ_CYCLE_COUNT-1.
- query_hv_segment  output  DIMS_PER_CC  current segment bits.
- seg_first  output  1  current segment has query_ctr==0.
- seg_last  output  1  current segment has query_ctr==SEQ_CYCLE_COUNT-1.
- busy  output  1  active or pending query held.

Behaviour:
- Reset (async assert on rst_n low, sync release):
  - seg_valid=0, query_ctr=0, query_hv_segment=0, seg_first=0, seg_last=0, busy=0.
  - Active and pending buffers empty.
  - q_ready=1 from the first clock after release, and 0 while rst_n is low.
- Storage: active register (query being streamed) and pending register (next query).
- q_ready = !pending_full. It is combinational from registered state and does not depend on q_valid or seg_ready.
- A query transfer occurs on q_valid && q_ready at the clock edge.
- A segment transfer occurs on seg_valid && seg_ready at the clock edge.
- All segment outputs are registered. While seg_valid && !seg_ready, query_ctr, query_hv_segment, seg_first and seg_last hold stable.
- State machine:
  - IDLE: seg_valid=0. A query transfer loads the active register, sets query_ctr=0 and seg_valid=1 on the next cycle (latency 1), then goes to STREAM.
  - STREAM, non-last transfer: query_ctr increments by 1 and the next segment is presented the following cycle.
  - STREAM, last transfer with pending full: pending moves to active, query_ctr=0, seg_valid stays 1 (no bubble), pending empties.
  - STREAM, last transfer, pending empty, simultaneous query transfer: the incoming query goes directly to active with query_ctr=0 and seg_valid stays 1.
  - STREAM, last transfer, pending empty, no query transfer: go to IDLE, seg_valid=0, query_ctr=0.
  - STREAM, query transfer without a last transfer: the query goes to pending.
- A query transfer while pending is full is impossible, because q_ready=0.
- query_ctr never exceeds SEQ_CYCLE_COUNT-1 and wraps to 0 only through a query reload.
- seg_first = seg_valid && query_ctr==0.
- seg_last = seg_valid && query_ctr==SEQ_CYCLE_COUNT-1.
- With SEQ_CYCLE_COUNT=1, seg_first and seg_last assert together.
- busy = active_full || pending_full.
- Reset asserted mid-stream aborts immediately. All queries are discarded and no partial segments are emitted after release.

Optional Feature:
- Macro: AM_QUERY_DENSITY_EN.
- When defined:
  - Adds output query_density, width $clog2(SEQ_CYCLE_COUNT*DIMS_PER_CC+1).
  - The block computes the popcount of q_hv on every query transfer and stores it alongside that query in active or pending.
  - query_density presents the active query's count whenever seg_valid=1, and holds 0 in reset and IDLE.
  - It is used for sparse similarity normalization.
- When undefined: the port and the popcount logic are absent; all other behaviour is identical.

Test Plan:
- Single query, seg_ready=1, defaults: q_hv segment k = k+1 → seg_valid rises 1 cycle after acceptance; 10 consecutive cycles with query_ctr 0..9, segment k+1, seg_first on ctr 0, seg_last on ctr 9; then IDLE.
- Backpressure: seg_ready=0 for 3 cycles at ctr 4 → ctr 4 and segment 5 held stable 3 cycles; ctr 5 follows the cycle after seg_ready=1.
- Back-to-back: second query offered during streaming → accepted into pending, q_ready drops to 0; ctr 9 of query A is followed the next cycle by ctr 0 of query B, with no bubble.
- Simultaneous last-segment and query transfer with pending empty → next cycle ctr=0 of the new query, seg_valid continuous, q_ready remains 1.
- rst_n pulsed low at ctr 6 with pending full → outputs zero immediately; after release seg_valid=0, busy=0, q_ready=1, and the old queries never reappear.
- AM_QUERY_DENSITY_EN defined: query with 37 ones → query_density=37 for all 10 segments; an all-zero query gives 0; an all-ones query gives 640.
